// File: rtl/usb_frame_packetizer.sv
// Sample FIFO plus framing FSM that emits HDR, LEN, FRAME_LEN samples and an optional
// checksum word (enabled by defining USB_FRAME_CHECKSUM_EN) toward the USB bridge.
module usb_frame_packetizer #(
  parameter int          FRAME_LEN  = 256,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [15:0] HDR_WORD   = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        usb_txe_n,
  output logic        usb_wr,
  output logic [15:0] usb_data_out,
  output logic        frame_done,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [PW-1:0] FRAME_LEN_P = PW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT    = CW'(FRAME_LEN - 1);
  localparam logic [15:0]   LEN_WORD    = 16'(FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
`ifdef USB_FRAME_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_DONE = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           usb_wr_q, usb_wr_d;
  logic [15:0]    data_q, data_d;
  logic           frame_done_q, frame_done_d;
  logic           overflow_q, overflow_d;
`ifdef USB_FRAME_CHECKSUM_EN
  logic [15:0]    sum_q, sum_d;
`endif

  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]  count;
  logic           full;
  logic           push;
  logic           emit;
  logic [15:0]    head;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = s_valid && !full;
  assign emit  = !usb_txe_n;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  // The whole frame is buffered before HDR, so DATA never underruns.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    usb_wr_d     = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (s_valid & full);
`ifdef USB_FRAME_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count >= FRAME_LEN_P) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
`ifdef USB_FRAME_CHECKSUM_EN
        sum_d = 16'h0000;
`endif
        if (emit) begin
          data_d   = HDR_WORD;
          usb_wr_d = 1'b1;
          state_d  = ST_LEN;
        end else begin
          state_d  = ST_HDR;
        end
      end
      ST_LEN: begin
        cnt_d = '0;
        if (emit) begin
          data_d   = LEN_WORD;
          usb_wr_d = 1'b1;
          state_d  = ST_DATA;
        end else begin
          state_d  = ST_LEN;
        end
      end
      ST_DATA: begin
        if (emit) begin
          data_d   = head;
          usb_wr_d = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef USB_FRAME_CHECKSUM_EN
          sum_d    = sum_q + head;
`endif
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef USB_FRAME_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef USB_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        if (emit) begin
          data_d   = 16'h0000 - sum_q;
          usb_wr_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_CSUM;
        end
      end
`endif
      ST_DONE: begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      usb_wr_q     <= 1'b0;
      data_q       <= 16'h0000;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef USB_FRAME_CHECKSUM_EN
      sum_q        <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      usb_wr_q     <= usb_wr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
`ifdef USB_FRAME_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign s_ready      = !full;
  assign usb_wr       = usb_wr_q;
  assign usb_data_out = data_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

endmodule
